// File: rtl/scaler_window_ctrl_pkg.sv
// Shared types and constants for the scaler window controller.
// State encoding is visible on the STATE debug port, so the values are fixed.
package scaler_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // 1.2 s of CLK120 without a PPS rising edge.
  localparam int unsigned PPS_TIMEOUT_DEF = 144000000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/scaler_window_ctrl_gate_gen.sv
// Window boundary generator: PPS rising-edge detect, internal period counter
// and PPS watchdog. Counters sit at zero while the controller is idle.
module scaler_gate_gen #(
  parameter int          PERIOD_W    = 28,
  parameter int unsigned PPS_TIMEOUT = 144000000
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_active,
  input  logic                i_gate_sel,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_pps,
  output logic                o_gate_edge,
  output logic                o_timeout
);

  localparam logic [PERIOD_W-1:0] PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]         TO_LAST = 32'(PPS_TIMEOUT - 1);

  logic                r_pps_d;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [31:0]         r_to_cnt;
  logic                w_pps_rise;
  logic                w_period_hit;
  logic                w_gate_edge;

  assign w_pps_rise   = i_pps & ~r_pps_d;
  // PERIOD=0 never matches, so that window stays open indefinitely.
  assign w_period_hit = (i_period != '0) && (r_per_cnt == (i_period - PER_ONE));
  assign w_gate_edge  = i_active & (i_gate_sel ? w_period_hit : w_pps_rise);

  assign o_gate_edge = w_gate_edge;
  // r_to_cnt holds the cycles elapsed since the last edge or since ARM entry.
  assign o_timeout   = i_active & ~i_gate_sel & ~w_gate_edge & (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_pps_d   <= 1'b0;
      r_per_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_pps_d <= i_pps;
      if (!i_active) begin
        r_per_cnt <= '0;
        r_to_cnt  <= '0;
      end else begin
        r_per_cnt <= w_period_hit ? '0 : r_per_cnt + PER_ONE;
        r_to_cnt  <= w_gate_edge ? 32'd1
                   : (r_to_cnt == 32'hFFFF_FFFF) ? r_to_cnt : r_to_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/scaler_window_ctrl.sv
// Scaler window sequencer: snapshots a free-running scaler count at each
// window boundary and presents the per-window delta with a valid/ack handshake.
module scaler_window_ctrl
  import scaler_window_ctrl_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int          PERIOD_W    = 28,
  parameter int          SEQ_W       = 16,
  parameter int unsigned PPS_TIMEOUT = PPS_TIMEOUT_DEF
) (
  input  logic                CLK120,
  input  logic                RESETN,
  input  logic                ENABLE,
  input  logic                GATE_SEL,
  input  logic [PERIOD_W-1:0] PERIOD,
  input  logic                PPS,
  input  logic [CNT_W-1:0]    SCALER_COUNT,
  output logic                SCALER_CLEAR,
  output logic [CNT_W-1:0]    RESULT_COUNT,
  output logic [31:0]         RESULT_CYCLES,
  output logic [SEQ_W-1:0]    RESULT_SEQ,
  output logic                RESULT_VALID,
  input  logic                RESULT_ACK,
  output logic                OVERRUN,
  output logic                PPS_MISSING,
  output logic [1:0]          STATE
);

  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

  // Handshake: RESULT_VALID rises the cycle after a window closes and holds
  // until a cycle with RESULT_ACK=1 and no new result; a new result arriving
  // while VALID=1 without ACK overwrites it and sets OVERRUN.
  state_t              r_state;
  state_t              w_next_state;
  logic                r_gate_sel;
  logic [PERIOD_W-1:0] r_period;
  logic [CNT_W-1:0]    r_base;
  logic [31:0]         r_cyc;
  logic [CNT_W-1:0]    r_res_count;
  logic [31:0]         r_res_cycles;
  logic [SEQ_W-1:0]    r_seq;
  logic                r_valid;
  logic                r_overrun;
  logic                r_pps_missing;
  logic                r_scaler_clear;

  logic w_active;
  logic w_gate_edge;
  logic w_timeout;
  logic w_start;
  logic w_rebase;
  logic w_new_result;

  assign w_active = (r_state != ST_IDLE);

  scaler_gate_gen #(
    .PERIOD_W   (PERIOD_W),
    .PPS_TIMEOUT(PPS_TIMEOUT)
  ) u_gate_gen (
    .i_clk      (CLK120),
    .i_rstn     (RESETN),
    .i_active   (w_active),
    .i_gate_sel (r_gate_sel),
    .i_period   (r_period),
    .i_pps      (PPS),
    .o_gate_edge(w_gate_edge),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge CLK120) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Dropping ENABLE wins over a coincident gate edge: no partial window result.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (ENABLE) w_next_state = ST_ARM;
      ST_ARM: begin
        if (!ENABLE)          w_next_state = ST_IDLE;
        else if (w_gate_edge) w_next_state = ST_RUN;
      end
      ST_RUN:  if (!ENABLE) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start      = 1'b0;
    w_rebase     = 1'b0;
    w_new_result = 1'b0;
    case (r_state)
      ST_IDLE: w_start      = ENABLE;
      ST_ARM:  w_rebase     = ENABLE & w_gate_edge;
      ST_RUN: begin
        w_rebase     = ENABLE & w_gate_edge;
        w_new_result = ENABLE & w_gate_edge;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK120) begin
    if (!RESETN) begin
      r_gate_sel     <= 1'b0;
      r_period       <= '0;
      r_base         <= '0;
      r_cyc          <= '0;
      r_res_count    <= '0;
      r_res_cycles   <= '0;
      r_seq          <= '0;
      r_valid        <= 1'b0;
      r_overrun      <= 1'b0;
      r_pps_missing  <= 1'b0;
      r_scaler_clear <= 1'b0;
    end else begin
      r_scaler_clear <= w_start;
      if (w_start) begin
        r_gate_sel    <= GATE_SEL;
        r_period      <= PERIOD;
        r_overrun     <= 1'b0;
        r_pps_missing <= 1'b0;
      end
      if (w_rebase) begin
        r_base <= SCALER_COUNT;
        r_cyc  <= 32'd1;
      end else if (r_state == ST_RUN) begin
        r_cyc <= sat_inc32(r_cyc);
      end
      // Modular subtraction makes scaler wrap-around transparent.
      if (w_new_result) begin
        r_res_count  <= SCALER_COUNT - r_base;
        r_res_cycles <= r_cyc;
        r_seq        <= r_seq + SEQ_ONE;
        r_valid      <= 1'b1;
        if (r_valid && !RESULT_ACK) r_overrun <= 1'b1;
      end else if (RESULT_ACK && r_valid) begin
        r_valid <= 1'b0;
      end
      if (w_timeout && ENABLE) r_pps_missing <= 1'b1;
    end
  end

  assign SCALER_CLEAR  = r_scaler_clear;
  assign RESULT_COUNT  = r_res_count;
  assign RESULT_CYCLES = r_res_cycles;
  assign RESULT_SEQ    = r_seq;
  assign RESULT_VALID  = r_valid;
  assign OVERRUN       = r_overrun;
  assign PPS_MISSING   = r_pps_missing;
  assign STATE         = r_state;

endmodule

// File: tb/tb_scaler_window_ctrl.sv
// Bench for scaler_window_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a window-level reference model.
module tb_scaler_window_ctrl;

  localparam int T_OUT = 1200;

  logic        clk = 1'b0;
  logic        rstn, en, gsel, pps, ack;
  logic [27:0] per;
  logic [31:0] sc;
  logic        scaler_clear, result_valid, overrun, pps_missing;
  logic [31:0] result_count, result_cycles;
  logic [15:0] result_seq;
  logic [1:0]  state;

  always #5 clk = ~clk;

  scaler_window_ctrl #(
    .CNT_W(32), .PERIOD_W(28), .SEQ_W(16), .PPS_TIMEOUT(T_OUT)
  ) dut (
    .CLK120       (clk),
    .RESETN       (rstn),
    .ENABLE       (en),
    .GATE_SEL     (gsel),
    .PERIOD       (per),
    .PPS          (pps),
    .SCALER_COUNT (sc),
    .SCALER_CLEAR (scaler_clear),
    .RESULT_COUNT (result_count),
    .RESULT_CYCLES(result_cycles),
    .RESULT_SEQ   (result_seq),
    .RESULT_VALID (result_valid),
    .RESULT_ACK   (ack),
    .OVERRUN      (overrun),
    .PPS_MISSING  (pps_missing),
    .STATE        (state)
  );

  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;
  int     ack_mode, inc_mode, pps_mode, pps_per;
  longint pps_phase;

  // Reference model: windows described by the cycle indices of their edges.
  int          m_state;
  bit          m_gsel;
  longint      m_per, m_arm_c, m_base_c, m_ref_c;
  logic [31:0] m_base, m_cnt, m_cyc;
  logic [15:0] m_seq;
  bit          m_valid, m_ovr, m_miss, m_clr, m_prev_pps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  function automatic bit m_gate(input longint c, input bit p);
    if (m_state == 0) return 1'b0;
    if (m_gsel) return (m_per != 0) && (((c - m_arm_c) % m_per) == m_per - 1);
    return p && !m_prev_pps;
  endfunction

  task automatic model_step(input longint c);
    bit edge_now, strobe, new_res;
    longint d;
    if (!rstn) begin
      m_state = 0; m_gsel = 0; m_per = 0; m_arm_c = 0; m_base_c = 0; m_ref_c = 0;
      m_base = 0; m_cnt = 0; m_cyc = 0; m_seq = 0;
      m_valid = 0; m_ovr = 0; m_miss = 0; m_clr = 0; m_prev_pps = 0;
      return;
    end
    edge_now = m_gate(c, pps);
    strobe   = (m_state != 0) && !m_gsel && !edge_now && (c - m_ref_c == T_OUT - 1);
    new_res  = 0;
    m_clr    = 0;
    if (m_state == 0) begin
      if (en) begin
        m_gsel = gsel; m_per = longint'(per);
        m_arm_c = c + 1; m_ref_c = c + 1;
        m_clr = 1; m_ovr = 0; m_miss = 0; m_state = 1;
      end
    end else if (!en) begin
      m_state = 0;
    end else begin
      if (edge_now) begin
        if (m_state == 2) begin
          new_res = 1;
          m_cnt = sc - m_base;
          d = c - m_base_c;
          m_cyc = (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
        end
        m_base = sc; m_base_c = c; m_ref_c = c; m_state = 2;
      end
      if (strobe) m_miss = 1;
    end
    if (new_res) begin
      if (m_valid && !ack) m_ovr = 1;
      m_valid = 1;
      m_seq = m_seq + 16'd1;
    end else if (ack && m_valid) begin
      m_valid = 0;
    end
    m_prev_pps = pps;
  endtask

  task automatic check_all();
    chk("state",   32'(state),         32'(m_state));
    chk("clear",   32'(scaler_clear),  32'(m_clr));
    chk("count",   result_count,       m_cnt);
    chk("cycles",  result_cycles,      m_cyc);
    chk("seq",     32'(result_seq),    32'(m_seq));
    chk("valid",   32'(result_valid),  32'(m_valid));
    chk("overrun", 32'(overrun),       32'(m_ovr));
    chk("missing", 32'(pps_missing),   32'(m_miss));
  endtask

  task automatic tick();
    if (inc_mode == 1 && (cyc % 4) == 0) sc = sc + 32'd1;
    else if (inc_mode == 2) sc = sc + 32'($urandom_range(0, 3));
    case (pps_mode)
      1:       pps = (cyc >= pps_phase) && (((cyc - pps_phase) % pps_per) < 10);
      2:       if ($urandom_range(0, 19) == 0) pps = ~pps;
      default: pps = 1'b0;
    endcase
    case (ack_mode)
      1:       ack = m_valid;
      2:       ack = ($urandom_range(0, 2) == 0);
      3:       ack = m_gate(cyc, pps) && (m_state == 2) && en;
      default: ack = 1'b0;
    endcase
    @(posedge clk);
    model_step(cyc);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic wait_seq(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (!(result_valid === 1'b1 && result_seq === target) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t0, e;
    int n, nclr;
    logic [15:0] seq_before;

    rstn = 0; en = 0; gsel = 0; per = '0; pps = 0; sc = '0; ack = 0;
    ack_mode = 0; inc_mode = 0; pps_mode = 0; pps_per = 1000; pps_phase = 0;

    // Reset state
    en = 1;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_clear", 32'(scaler_clear), 32'd0);
    en = 0; rstn = 1;
    tick();

    // Period mode, PERIOD=1000, one event every 4 cycles, every result acked
    gsel = 1; per = 28'd1000; inc_mode = 1; ack_mode = 1; en = 1;
    t0 = cyc;
    wait_seq("p_res1", 16'd1, 2500);
    chk("p_latency", 32'(cyc - t0), 32'd2001);
    chk("p_count1", result_count, 32'd250);
    chk("p_cycles1", result_cycles, 32'd1000);
    wait_seq("p_res2", 16'd2, 1100);
    chk("p_count2", result_count, 32'd250);
    wait_seq("p_res3", 16'd3, 1100);
    chk("p_count3", result_count, 32'd250);
    chk("p_cycles3", result_cycles, 32'd1000);

    // Scaler wrap-around inside one window
    en = 0; repeat (3) tick();
    ack_mode = 0; inc_mode = 0; per = 28'd50; sc = 32'hFFFF_FF00; en = 1;
    n = 0;
    while (state !== 2'd2 && n < 200) begin tick(); n++; end
    chk("w_run", 32'(n < 200), 32'd1);
    sc = 32'h0000_0010;
    wait_seq("w_res", m_seq + 16'd1, 200);
    chk("w_count", result_count, 32'h110);
    chk("w_cycles", result_cycles, 32'd50);

    // Reset for one cycle mid-RUN with a result pending
    repeat (10) tick();
    chk("r_pending", 32'(result_valid), 32'd1);
    rstn = 0;
    tick();
    chk("r_state", 32'(state), 32'd0);
    chk("r_valid", 32'(result_valid), 32'd0);
    chk("r_seq", 32'(result_seq), 32'd0);
    chk("r_count", result_count, 32'd0);
    rstn = 1; en = 0;
    tick();

    // Overrun: two unacked windows, then ACK coinciding with the third result
    per = 28'd100; inc_mode = 2; ack_mode = 0; en = 1;
    wait_seq("o_res1", 16'd1, 400);
    wait_seq("o_res2", 16'd2, 200);
    chk("o_overrun", 32'(overrun), 32'd1);
    chk("o_valid", 32'(result_valid), 32'd1);
    chk("o_seq", 32'(result_seq), 32'd2);
    ack_mode = 3;
    wait_seq("o_res3", 16'd3, 200);
    chk("o_valid3", 32'(result_valid), 32'd1);
    chk("o_seq3", 32'(result_seq), 32'd3);
    ack_mode = 1;
    repeat (3) tick();
    chk("o_drained", 32'(result_valid), 32'd0);

    // PPS mode, edges 1000 cycles apart
    en = 0; repeat (2) tick();
    gsel = 0; pps_mode = 1; pps_per = 1000; pps_phase = cyc + 20; en = 1;
    wait_seq("s_res1", m_seq + 16'd1, 3000);
    wait_seq("s_res2", m_seq + 16'd1, 1100);
    chk("s_cycles", result_cycles, 32'd1000);
    chk("s_missing", 32'(pps_missing), 32'd0);

    // PPS withheld: watchdog fires exactly T_OUT cycles after the last edge
    pps_mode = 0;
    e = m_ref_c;
    n = 0;
    while (pps_missing !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("m_seen", 32'(n < 2000), 32'd1);
    chk("m_delay", 32'(cyc - e), 32'(T_OUT));
    pps_mode = 1; pps_phase = cyc + 30;
    wait_seq("m_res", m_seq + 16'd1, 1200);
    chk("m_long", 32'(result_cycles > 32'(T_OUT)), 32'd1);
    chk("m_sticky", 32'(pps_missing), 32'd1);

    // ENABLE dropped mid-window, then re-enabled
    en = 0; repeat (2) tick();
    gsel = 1; per = 28'd300; pps_mode = 0; en = 1;
    wait_seq("d_res", m_seq + 16'd1, 700);
    repeat (150) tick();
    seq_before = m_seq;
    en = 0;
    repeat (20) tick();
    chk("d_nores", 32'(result_seq), 32'(seq_before));
    chk("d_idle", 32'(state), 32'd0);
    en = 1;
    nclr = 0;
    repeat (10) begin tick(); nclr += int'(scaler_clear); end
    chk("d_clear_once", 32'(nclr), 32'd1);

    // Randomized traffic: config churn, random PPS/ACK/scaler, enable drops, resets
    for (int seg = 0; seg < 8; seg++) begin
      pps_mode = 2; ack_mode = 2; inc_mode = 2;
      repeat (700) begin
        if ($urandom_range(0, 199) == 0) en = ~en;
        else if (!en && $urandom_range(0, 9) == 0) en = 1;
        gsel = 1'($urandom_range(0, 1));
        per  = 28'($urandom_range(0, 40));
        rstn = ($urandom_range(0, 599) != 0);
        tick();
      end
      rstn = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
